// File: rtl/gpio_pkg.sv
// Shared defaults and the counter-width helper for the GPIO debouncer.
package gpio_pkg;

  localparam int unsigned WIDTH_DEF     = 8;
  localparam int unsigned DB_CYCLES_DEF = 1000;

  // Wide enough to hold DB_CYCLES itself, so any legal count fits.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One pin: 2-flop synchronizer, stability counter, debounced level and edge pulses.
// Latency: held level shows on level_o DB_CYCLES+1 edges after first sample; no backpressure.
module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic pad_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic rise_nxt_o,
  output logic fall_nxt_o
);

  localparam int unsigned   CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          mismatch;
  logic          accept;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], pad_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Accepting on the last mismatch cycle also clears the count, so it never wraps.
  always_comb begin
    mismatch = sync_q[1] ^ level_q;
    accept   = mismatch && (cnt_q == CNT_LAST);
    cnt_d    = (!mismatch || accept) ? '0 : cnt_q + 1'b1;
    level_d  = accept ? sync_q[1] : level_q;
    rise_d   = accept &&  sync_q[1];
    fall_d   = accept && !sync_q[1];
  end

  assign level_o    = level_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign rise_nxt_o = rise_d;
  assign fall_nxt_o = fall_d;

endmodule

// File: rtl/gpio_debounce.sv
// Debounced GPIO inputs with edge pulses, sticky per-bit events and a combined interrupt.
// Latency: DB_CYCLES+1 edges pad to gpio_o, events in the same cycle as the pulse; no backpressure.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] pad_i,
  input  logic [WIDTH-1:0] edge_sel_i,
  input  logic [WIDTH-1:0] both_i,
  input  logic [WIDTH-1:0] irq_en_i,
  input  logic [WIDTH-1:0] evt_clr_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] evt_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;
  logic [WIDTH-1:0] evt_set;
  logic [WIDTH-1:0] evt_q, evt_d;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    gpio_debounce_bit #(
      .DB_CYCLES (DB_CYCLES)
    ) u_bit (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .pad_i      (pad_i[g]),
      .level_o    (gpio_o[g]),
      .rise_o     (rise_o[g]),
      .fall_o     (fall_o[g]),
      .rise_nxt_o (rise_nxt[g]),
      .fall_nxt_o (fall_nxt[g])
    );
  end

  // Next-state pulses let the sticky flag rise together with the registered pulse.
  always_comb begin
    evt_set = (both_i & (rise_nxt | fall_nxt))
            | (~both_i & ((edge_sel_i & rise_nxt) | (~edge_sel_i & fall_nxt)));
    evt_d   = (evt_q & ~evt_clr_i) | evt_set;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign evt_o = evt_q;
  assign irq_o = |(evt_q & irq_en_i);

endmodule

// File: doc/gpio_debounce.md
GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of GPIO input bits.
REQ-002 SHALL have parameter DB_CYCLES, default 1000, consecutive stable cycles required to accept a new level; legal range 1..65535.
REQ-003 SHALL have port i_clk, input, 1, single clock for all logic.
REQ-004 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port pad_i, input, WIDTH, raw asynchronous pin levels.
REQ-006 SHALL have port edge_sel_i, input, WIDTH, per bit: 1 = rising-edge event, 0 = falling-edge event.
REQ-007 SHALL have port both_i, input, WIDTH, per bit: 1 = any edge is an event (overrides edge_sel_i).
REQ-008 SHALL have port irq_en_i, input, WIDTH, per-bit interrupt enable.
REQ-009 SHALL have port evt_clr_i, input, WIDTH, per-bit one-cycle clear of sticky event.
REQ-010 SHALL have port gpio_o, output, WIDTH, debounced level; drives gpio_i of the wishbone GPIO register block.
REQ-011 SHALL have port rise_o, output, WIDTH, one-cycle pulse on debounced 0->1.
REQ-012 SHALL have port fall_o, output, WIDTH, one-cycle pulse on debounced 1->0.
REQ-013 SHALL have port evt_o, output, WIDTH, sticky event flags.
REQ-014 SHALL have port irq_o, output, 1, interrupt request.

Function
REQ-015 Each bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-016 Each bit SHALL have a counter of width clog2(DB_CYCLES+1); it increments each cycle synchronized level != gpio_o, and clears to 0 whenever they are equal.
REQ-017 When mismatch persists and counter == DB_CYCLES-1, gpio_o bit SHALL take the synchronized level at that edge and the counter SHALL clear.
REQ-018 Latency: a pad level first sampled at edge k and held SHALL appear on gpio_o at edge k+DB_CYCLES+1.
REQ-019 A pad excursion shorter than DB_CYCLES cycles SHALL NOT change gpio_o or generate any event.
REQ-020 The counter SHALL never wrap; it cannot exceed DB_CYCLES-1.
REQ-021 rise_o/fall_o SHALL be registered and high exactly in the first cycle gpio_o shows the new level.
REQ-022 evt_o bit SHALL set in the same cycle as a qualifying rise_o/fall_o pulse per both_i/edge_sel_i.
REQ-023 evt_o bit SHALL clear on evt_clr_i; simultaneous set and clear SHALL leave evt_o = 1 (set wins).
REQ-024 irq_o SHALL equal OR of (evt_o & irq_en_i), combinational from registers, no added latency.
REQ-025 Bits SHALL operate fully independently; simultaneous events on all bits SHALL all be captured.

Reset
REQ-026 i_reset_n low SHALL asynchronously clear synchronizers, counters, gpio_o, rise_o, fall_o, evt_o; irq_o therefore 0.
REQ-027 Reset asserted mid-count SHALL discard the count; after release a full DB_CYCLES stability period is required.
REQ-028 A pad held high through reset release SHALL produce gpio_o = 1 after REQ-018 latency and a rise event.

Structure
REQ-029 Default WIDTH, DB_CYCLES and the counter-width function SHALL live in a shared package gpio_pkg.
REQ-030 Per-bit synchronizer + counter + level + edge pulses SHALL be sub-module gpio_debounce_bit, instantiated WIDTH times by generate; sticky flags and irq stay in the top.

Verification (DB_CYCLES=4, WIDTH=8)
REQ-031 pad_i[0] 0->1 first sampled edge 10, edge_sel_i[0]=1, irq_en_i[0]=1 -> gpio_o[0]=1 after edge 15, rise_o[0] high one cycle, evt_o[0]=1, irq_o=1.
REQ-032 pad_i[3] high for 3 cycles then low -> gpio_o, rise_o, fall_o, evt_o all remain 0.
REQ-033 evt_o[0]=1, evt_clr_i[0] pulse -> evt_o[0]=0, irq_o=0 next cycle; clear coincident with new rise -> evt_o[0] stays 1.
REQ-034 pad_i[5] high, reset asserted when counter=2, released -> outputs 0 asynchronously; gpio_o[5]=1 exactly 5 edges after first post-release sampling edge.
REQ-035 both_i=8'hFF, pad_i 8'h00->8'hFF for 10 cycles ->8'h00 -> all evt_o bits set on rise; after clear, all set again on fall; fall_o=8'hFF one cycle.
